// File: rtl/ysyx_22040365_rf_wb_arb.sv
// Register-file writeback arbiter: round-robin between EXU (req0) and LSU (req1), one registered write per cycle.
// Define YSYX_22040365_RF_SCOREBOARD_EN to build the per-register pending-write (busy) scoreboard.
module ysyx_22040365_rf_wb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [ADDR_WIDTH-1:0]        req0_addr,
    input  logic [DATA_WIDTH-1:0]        req0_data,
    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [ADDR_WIDTH-1:0]        req1_addr,
    input  logic [DATA_WIDTH-1:0]        req1_data,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    input  logic                         mark_valid,
    input  logic [ADDR_WIDTH-1:0]        mark_addr,
    input  logic                         flush,
    output logic [(2**ADDR_WIDTH)-1:0]   busy
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // 0: requester 0 was granted last, 1: requester 1 was granted last
    logic                  last_grant_reg;
    logic                  grant0;
    logic                  grant1;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  rf_wen_reg;
    logic [ADDR_WIDTH-1:0] rf_waddr_reg;
    logic [DATA_WIDTH-1:0] rf_wdata_reg;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_reg;
                grant1 = !last_grant_reg;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign handshake  = grant0 | grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rf_wen_reg     <= 1'b0;
            rf_waddr_reg   <= '0;
            rf_wdata_reg   <= '0;
        end else begin
            // x0 is hardwired: the handshake completes but no write is issued
            rf_wen_reg <= handshake && (sel_addr != '0);
            if (handshake) begin
                last_grant_reg <= grant1;
                rf_waddr_reg   <= sel_addr;
                rf_wdata_reg   <= sel_data;
            end
        end
    end

    assign rf_wen   = rf_wen_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

`ifdef YSYX_22040365_RF_SCOREBOARD_EN
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            logic busy_bit_reg;
            // Priority: flush clears everything, then a new mark beats a same-cycle writeback
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    busy_bit_reg <= 1'b0;
                end else if (flush) begin
                    busy_bit_reg <= 1'b0;
                end else if (mark_valid && (mark_addr == ADDR_WIDTH'(gi))) begin
                    busy_bit_reg <= 1'b1;
                end else if (handshake && (sel_addr == ADDR_WIDTH'(gi))) begin
                    busy_bit_reg <= 1'b0;
                end
            end
            assign busy[gi] = busy_bit_reg;
        end
    endgenerate
    assign busy[0] = 1'b0;
`else
    logic unused_scoreboard_inputs;
    assign unused_scoreboard_inputs = ^{mark_valid, mark_addr, flush, NUM_REGS[0]};
    assign busy = '0;
`endif

endmodule
